// File: rtl/wb_rr_master_arbiter_if.sv
// rtl/wb_rr_master_arbiter_if.sv - request/response and grant bundle for wb_rr_master_arbiter
interface wb_rr_master_arbiter_if #(
  parameter int N_MASTER = 4,
  localparam int IDXW = $clog2(N_MASTER)
);
  logic [N_MASTER-1:0] cyc_i;
  logic [N_MASTER-1:0] stb_i;
  logic [N_MASTER-1:0] lock_i;
  logic                ack_i;
  logic                err_i;
  logic                rty_i;
  logic [N_MASTER-1:0] gnt_o;
  logic [IDXW-1:0]     gnt_idx_o;
  logic                busy_o;
  logic                timeout_o;

  // master: requesters and shared slave response side
  modport master (
    output cyc_i, stb_i, lock_i, ack_i, err_i, rty_i,
    input  gnt_o, gnt_idx_o, busy_o, timeout_o
  );

  // slave: the arbiter itself
  modport slave (
    input  cyc_i, stb_i, lock_i, ack_i, err_i, rty_i,
    output gnt_o, gnt_idx_o, busy_o, timeout_o
  );
endinterface

// File: rtl/wb_rr_master_arbiter.sv
// rtl/wb_rr_master_arbiter.sv - round-robin wishbone master arbiter; optional watchdog via WB_ARB_TIMEOUT_EN
module wb_rr_master_arbiter #(
  parameter int N_MASTER       = 4,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int IDXW = $clog2(N_MASTER)
) (
  input logic clk_i,
  input logic rst_i,
  wb_rr_master_arbiter_if.slave bus
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t              state;
  logic [N_MASTER-1:0] gnt_q;
  logic [IDXW-1:0]     idx_q;
  logic [IDXW-1:0]     ptr_q;
  logic                to_q;

  logic                hold;
  logic                abort;
  logic                found;
  logic [IDXW-1:0]     win;
  logic [N_MASTER-1:0] win_oh;
  logic [IDXW-1:0]     cand_idx;
  int                  cand;

  assign hold = bus.cyc_i[idx_q] | bus.lock_i[idx_q];

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wd_q;
  logic          stall;
  logic          rearb;

  assign stall = (state == OWNED) && bus.stb_i[idx_q] && !(bus.ack_i || bus.err_i || bus.rty_i);
  // Abort on the edge that would bring the stall count to TIMEOUT_CYCLES.
  assign abort = stall && (wd_q == WD_LAST);
  assign rearb = (state == OWNED) && (abort || !hold);

  always_ff @(posedge clk_i) begin
    if (rst_i || !stall || rearb) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  logic unused_resp;

  assign abort       = 1'b0;
  assign unused_resp = ^{bus.stb_i, bus.ack_i, bus.err_i, bus.rty_i};
`endif

  // Search upward from pointer+1; the pointer holds the last winner, so the
  // releasing owner is examined last and only wins when nobody else asks.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_oh   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= N_MASTER; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= N_MASTER) begin
        cand = cand - N_MASTER;
      end
      cand_idx = IDXW'(cand);
      if (!found && bus.cyc_i[cand_idx] && !(abort && (cand_idx == idx_q))) begin
        found = 1'b1;
        win   = cand_idx;
      end
    end
    win_oh[win] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      gnt_q <= '0;
      idx_q <= '0;
      ptr_q <= IDXW'(N_MASTER - 1);
      to_q  <= 1'b0;
    end else begin
      to_q <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state <= OWNED;
            gnt_q <= win_oh;
            idx_q <= win;
            ptr_q <= win;
          end
        end
        OWNED: begin
          if (abort || !hold) begin
            to_q <= abort;
            if (found) begin
              gnt_q <= win_oh;
              idx_q <= win;
              ptr_q <= win;
            end else begin
              state <= IDLE;
              gnt_q <= '0;
              idx_q <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.gnt_idx_o = idx_q;
  assign bus.busy_o    = |gnt_q;
  assign bus.timeout_o = to_q;

endmodule

// File: tb/tb_wb_rr_master_arbiter.sv
// tb/tb_wb_rr_master_arbiter.sv - directed and random checks of wb_rr_master_arbiter against a reference model
module tb_wb_rr_master_arbiter;

  localparam int N   = 4;
  localparam int TCY = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cyc = '0;
  logic [3:0] stb = '0;
  logic [3:0] lock = '0;
  logic       ack = 1'b0;
  logic       err = 1'b0;
  logic       rty = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: current owner (-1 = none), last winner, stall run length
  int m_owner = -1;
  int m_ptr   = N - 1;
  int m_cnt   = 0;
  bit m_to    = 1'b0;

  always #5 clk = ~clk;

  wb_rr_master_arbiter_if #(.N_MASTER(N)) bus ();

  assign bus.cyc_i  = cyc;
  assign bus.stb_i  = stb;
  assign bus.lock_i = lock;
  assign bus.ack_i  = ack;
  assign bus.err_i  = err;
  assign bus.rty_i  = rty;

  wb_rr_master_arbiter #(.N_MASTER(N), .TIMEOUT_CYCLES(TCY)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  function automatic bit bit_at(input logic [3:0] v, input int i);
    return v[i[1:0]];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit stall, abort, rel;
    int excl, w, j;
    if (rst) begin
      m_owner = -1;
      m_ptr   = N - 1;
      m_cnt   = 0;
      m_to    = 1'b0;
    end else begin
      stall = (m_owner >= 0) && bit_at(stb, m_owner) && !(ack || err || rty);
      abort = TO_EN && stall && (m_cnt + 1 == TCY);
      rel   = (m_owner < 0) || abort || !(bit_at(cyc, m_owner) || bit_at(lock, m_owner));
      m_to  = abort;
      m_cnt = stall ? m_cnt + 1 : 0;
      if (rel) begin
        excl = abort ? m_owner : -1;
        w    = -1;
        for (int k = 1; k <= N; k++) begin
          j = (m_ptr + k) % N;
          if (w < 0 && bit_at(cyc, j) && j != excl) w = j;
        end
        m_owner = w;
        if (w >= 0) m_ptr = w;
        m_cnt = 0;
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk({tag, ".gnt"},  32'(bus.gnt_o),     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk({tag, ".idx"},  32'(bus.gnt_idx_o), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk({tag, ".busy"}, 32'(bus.busy_o),    32'(m_owner >= 0));
    chk({tag, ".to"},   32'(bus.timeout_o), 32'(m_to));
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    tick("rst");
    chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);

    // single request: one-cycle grant latency
    rst = 1'b0;
    cyc = 4'b0001;
    tick("first");
    chk("first_gnt", 32'(bus.gnt_o), 32'h1);
    chk("first_busy", 32'(bus.busy_o), 32'd1);

    // all requesting, owners drop cyc for one cycle: 1,2,3,0 with no gap
    cyc = 4'b1111;
    for (int t = 0; t < 4; t++) begin
      cyc = 4'b1111 & ~(4'b0001 << bus.gnt_idx_o);
      tick("rr_drop");
      chk("rr_idx", 32'(bus.gnt_idx_o), 32'((t + 1) % 4));
      chk("rr_busy", 32'(bus.busy_o), 32'd1);
      cyc = 4'b1111;
      tick("rr_hold");
    end

    // lock keeps owner 2 after cyc drops
    cyc = 4'b0100;
    tick("lk_get2");
    chk("lk_own2", 32'(bus.gnt_o), 32'h4);
    lock = 4'b0100;
    cyc  = 4'b0001;
    for (int t = 0; t < 3; t++) begin
      tick("lk_hold");
      chk("lk_held", 32'(bus.gnt_o), 32'h4);
    end
    lock = 4'b0000;
    tick("lk_rel");
    chk("lk_next", 32'(bus.gnt_o), 32'h1);

    // master 1 re-request alone, then with master 3 competing
    cyc = 4'b0010;
    tick("rq_get1");
    chk("rq_own1", 32'(bus.gnt_o), 32'h2);
    cyc = 4'b0000;
    tick("rq_idle");
    chk("rq_idle", 32'(bus.busy_o), 32'd0);
    cyc = 4'b0010;
    tick("rq_again");
    chk("rq_regrant1", 32'(bus.gnt_o), 32'h2);
    cyc = 4'b0000;
    tick("rq_idle2");
    cyc = 4'b1010;
    tick("rq_both");
    chk("rq_three_first", 32'(bus.gnt_o), 32'h8);

    // reset while master 3 owns mid-burst; pointer returns to N-1
    cyc = 4'b1000;
    stb = 4'b1000;
    tick("mb_hold");
    rst = 1'b1;
    tick("mb_rst");
    chk("mb_rst_gnt", 32'(bus.gnt_o), 32'd0);
    rst = 1'b0;
    stb = 4'b0000;
    cyc = 4'b1001;
    tick("mb_after");
    chk("mb_ptr_reset", 32'(bus.gnt_o), 32'h1);

    // watchdog: owner 0 stalls with stb and no response
    cyc = 4'b0011;
    stb = 4'b0011;
    for (int t = 1; t < TCY; t++) begin
      tick("wd_stall");
      chk("wd_no_to_yet", 32'(bus.timeout_o), 32'd0);
    end
    tick("wd_abort");
    chk("wd_to_pulse", 32'(bus.timeout_o), 32'(TO_EN));
    chk("wd_gnt_moved", 32'(bus.gnt_o), TO_EN ? 32'h2 : 32'h1);
    // ack on the 7th stalled cycle restarts the count
    for (int t = 1; t < TCY - 1; t++) begin
      tick("wd_s2");
      chk("wd_s2_to", 32'(bus.timeout_o), 32'd0);
    end
    ack = 1'b1;
    tick("wd_ack");
    chk("wd_ack_to", 32'(bus.timeout_o), 32'd0);
    ack = 1'b0;
    for (int t = 1; t < TCY; t++) begin
      tick("wd_s3");
      chk("wd_s3_to", 32'(bus.timeout_o), 32'd0);
    end
    stb = 4'b0000;
    tick("wd_end");

    // randomized traffic against the model
    for (int t = 0; t < 4000; t++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(5) == 0) cyc[b] = ~cyc[b];
      end
      stb  = cyc & ~(($urandom_range(7) == 0) ? 4'($urandom) : 4'b0000);
      lock = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0000;
      ack  = (t >= 2000) ? ($urandom_range(15) == 0) : ($urandom_range(2) == 0);
      err  = ($urandom_range(40) == 0);
      rty  = ($urandom_range(40) == 0);
      rst  = ($urandom_range(299) == 0);
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
